// File: rtl/des_mode_ctrl_if.sv
// Bundle of the stream, IV-load, engine and debug signals of des_mode_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface des_mode_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CH     = 2
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once raised, valid and its payload hold until that transfer.
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        in_data;
    logic [CH_W-1:0]              in_ch;
    logic                         in_mode;
    logic                         in_encrypt;

    logic                         iv_load;
    logic [CH_W-1:0]              iv_ch;
    logic [DATA_WIDTH-1:0]        iv_data;

    logic                         core_start;
    logic                         core_encrypt;
    logic [DATA_WIDTH-1:0]        core_data;
    logic                         core_done;
    logic [DATA_WIDTH-1:0]        core_result;

    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;

    logic [LVL_W-1:0]             fifo_level;

    logic [1:0]                   dbg_state;
    logic [NUM_CH*DATA_WIDTH-1:0] dbg_iv;

    modport slave (
        input  in_valid, in_data, in_ch, in_mode, in_encrypt,
        input  iv_load, iv_ch, iv_data,
        input  core_done, core_result,
        input  out_ready,
        output in_ready, core_start, core_encrypt, core_data,
        output out_valid, out_data, out_ch, fifo_level,
        output dbg_state, dbg_iv
    );

    modport master (
        output in_valid, in_data, in_ch, in_mode, in_encrypt,
        output iv_load, iv_ch, iv_data,
        output core_done, core_result,
        output out_ready,
        input  in_ready, core_start, core_encrypt, core_data,
        input  out_valid, out_data, out_ch, fifo_level,
        input  dbg_state, dbg_iv
    );
endinterface

// File: rtl/des_mode_ctrl.sv
// ECB/CBC mode controller: input FIFO, per-channel chaining IVs and a
// start/done sequencer for an iterative block-cipher round engine.
module des_mode_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CH     = 2
) (
    input  logic           clk,
    input  logic           rst,
    des_mode_ctrl_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + 2 + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full, empty, push, pop;

    logic [ENT_W-1:0]      head;
    logic [CH_W-1:0]       head_ch;
    logic                  head_mode, head_enc;
    logic [DATA_WIDTH-1:0] head_data;

    logic [DATA_WIDTH-1:0] work_data_q, work_iv_q;
    logic [CH_W-1:0]       work_ch_q;
    logic                  work_mode_q, work_enc_q;
    logic [DATA_WIDTH-1:0] core_data_q;
    logic                  core_enc_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_ch_q;
    logic [DATA_WIDTH-1:0] iv_q [NUM_CH];

    logic                  capture, chain_upd, start_o, out_valid_o;
    logic [DATA_WIDTH-1:0] chain_val, result_val;

    // ---------------- input FIFO ----------------
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid && !full;

    assign head      = mem_q[rd_ptr_q];
    assign head_ch   = head[ENT_W-1 -: CH_W];
    assign head_mode = head[DATA_WIDTH+1];
    assign head_enc  = head[DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_ch, bus.in_mode, bus.in_encrypt, bus.in_data};
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        start_o     = 1'b0;
        out_valid_o = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_o = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- datapath ----------------
    // CBC decrypt un-whitens the engine output; every other case passes it through.
    assign result_val = (work_mode_q && !work_enc_q) ? (bus.core_result ^ work_iv_q)
                                                     : bus.core_result;
    assign chain_upd  = capture && work_mode_q;
    assign chain_val  = work_enc_q ? bus.core_result : work_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_data_q <= '0;
            work_iv_q   <= '0;
            work_ch_q   <= '0;
            work_mode_q <= 1'b0;
            work_enc_q  <= 1'b0;
            core_data_q <= '0;
            core_enc_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            if (pop) begin
                work_data_q <= head_data;
                work_iv_q   <= iv_q[head_ch];
                work_ch_q   <= head_ch;
                work_mode_q <= head_mode;
                work_enc_q  <= head_enc;
                core_data_q <= (head_mode && head_enc) ? (head_data ^ iv_q[head_ch])
                                                       : head_data;
                core_enc_q  <= head_enc;
            end
            if (capture) begin
                out_data_q <= result_val;
                out_ch_q   <= work_ch_q;
            end
        end
    end

    // An explicit load overrides a chaining update to the same channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) iv_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (chain_upd && (work_ch_q == CH_W'(c))) iv_q[c] <= chain_val;
                if (bus.iv_load && (bus.iv_ch == CH_W'(c))) iv_q[c] <= bus.iv_data;
            end
        end
    end

    always_comb begin
        bus.dbg_iv = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.dbg_iv[c*DATA_WIDTH +: DATA_WIDTH] = iv_q[c];
        end
    end

    assign bus.in_ready     = !full;
    assign bus.fifo_level   = level_q;
    assign bus.core_start   = start_o;
    assign bus.core_encrypt = core_enc_q;
    assign bus.core_data    = core_data_q;
    assign bus.out_valid    = out_valid_o;
    assign bus.out_data     = out_data_q;
    assign bus.out_ch       = out_ch_q;
    assign bus.dbg_state    = state_q;
endmodule
